// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM ramp sequencer.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dffe.sv
// Library flop: synchronous reset to zero with load enable.
module dffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (r)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/dffsr.sv
// Library flop: synchronous reset to zero (highest priority), synchronous set to all ones.
module dffsr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (r)
            q <= '0;
        else if (s)
            q <= '1;
        else
            q <= d;
    end

endmodule

// File: rtl/tick_gen.sv
// Ramp prescaler: counts 0..div while enabled and fires a tick on the compare cycle.
module tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] count_next;

    assign tick = en && (count == div);

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (en)
            count_next = tick ? '0 : count + DIV_WIDTH'(1);
    end

    dffsr #(.WIDTH(DIV_WIDTH)) u_count (
        .clk (clk),
        .r   (r),
        .s   (1'b0),
        .d   (count_next),
        .q   (count)
    );

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a pwm on_time toward a commanded target in fixed steps at a programmable tick rate,
// keeping the period constant and strobing set_time once per step.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_target,
    input  logic [WIDTH-1:0]     cmd_period,
    input  logic [WIDTH-1:0]     cmd_step,
    input  logic [DIV_WIDTH-1:0] cmd_div,
    input  logic                 abort,
    output logic [WIDTH-1:0]     on_time,
    output logic [WIDTH-1:0]     off_time,
    output logic                 set_time,
    output logic                 busy,
    output logic                 done
);

    state_t               state;
    state_t               state_next;
    logic [1:0]           state_q;
    logic                 accept;
    logic                 tick;
    logic                 finishing;
    logic                 update;
    logic [WIDTH-1:0]     target_in;
    logic [WIDTH-1:0]     step_in;
    logic [WIDTH-1:0]     period_q;
    logic [WIDTH-1:0]     step_q;
    logic [WIDTH-1:0]     target_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [WIDTH-1:0]     cur;
    logic [WIDTH-1:0]     cur_next;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;

    assign state     = state_t'(state_q);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RAMP) || (state == DONE);
    assign done      = (state == DONE);
    assign accept    = cmd_ready && cmd_valid;
    assign target_in = (cmd_target > cmd_period) ? cmd_period : cmd_target;
    assign step_in   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;

    dffe #(.WIDTH(WIDTH))     u_period (.clk(clk), .r(r), .en(accept), .d(cmd_period), .q(period_q));
    dffe #(.WIDTH(WIDTH))     u_step   (.clk(clk), .r(r), .en(accept), .d(step_in),    .q(step_q));
    dffe #(.WIDTH(WIDTH))     u_target (.clk(clk), .r(r), .en(accept), .d(target_in),  .q(target_q));
    dffe #(.WIDTH(DIV_WIDTH)) u_div    (.clk(clk), .r(r), .en(accept), .d(cmd_div),    .q(div_q));

    tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk  (clk),
        .r    (r),
        .clr  (accept),
        .en   (state == RAMP),
        .div  (div_q),
        .tick (tick)
    );

    // The ramp ends on the cycle its final strobe is visible, so a tick landing there is swallowed.
    assign finishing = set_time && (cur == target_q);
    assign update    = (state == RAMP) && tick && !abort && !finishing;

    assign sum  = {1'b0, cur} + {1'b0, step_q};
    assign diff = cur - target_q;

    always_comb begin
        cur_next = cur;
        if (cur < target_q)
            cur_next = (sum > {1'b0, target_q}) ? target_q : sum[WIDTH-1:0];
        else if (cur > target_q)
            cur_next = (diff <= step_q) ? target_q : cur - step_q;
    end

    dffe  #(.WIDTH(WIDTH)) u_cur (.clk(clk), .r(r), .en(update), .d(cur_next),            .q(cur));
    dffe  #(.WIDTH(WIDTH)) u_on  (.clk(clk), .r(r), .en(update), .d(cur_next),            .q(on_time));
    dffe  #(.WIDTH(WIDTH)) u_off (.clk(clk), .r(r), .en(update), .d(period_q - cur_next), .q(off_time));
    dffsr #(.WIDTH(1))     u_set (.clk(clk), .r(r), .s(1'b0),    .d(update),              .q(set_time));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = RAMP;
            RAMP:    if (abort || finishing) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    dffsr #(.WIDTH(2)) u_state (.clk(clk), .r(r), .s(1'b0), .d(state_next), .q(state_q));

endmodule
